// File: rtl/prg_fetch.sv
// Sequential fetch client for the single-port program memory.
// It walks START_ADDR..END_ADDR and streams {addr, word} through a 2-entry buffer.
module prg_fetch #(
    parameter int unsigned RAM_WIDTH     = 32,
    parameter int unsigned RAM_ADDR_BITS = 9,
    parameter int unsigned START_ADDR    = 0,
    parameter int unsigned END_ADDR      = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     redirect_valid,
    input  logic [RAM_ADDR_BITS-1:0] redirect_addr,
    output logic                     mem_enable,
    output logic                     mem_write_enable,
    output logic [RAM_ADDR_BITS-1:0] mem_address,
    output logic [RAM_WIDTH-1:0]     mem_in_data,
    input  logic [RAM_WIDTH-1:0]     mem_out_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [RAM_WIDTH-1:0]     instr_data,
    output logic [RAM_ADDR_BITS-1:0] instr_addr,
    output logic                     busy,
    output logic                     done
);

    localparam logic [RAM_ADDR_BITS-1:0] START_A = RAM_ADDR_BITS'(START_ADDR);
    localparam logic [RAM_ADDR_BITS-1:0] END_A   = RAM_ADDR_BITS'(END_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_e;

    typedef struct packed {
        logic [RAM_ADDR_BITS-1:0] addr;
        logic [RAM_WIDTH-1:0]     data;
    } entry_t;

    state_e                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] pc_q, pc_d;
    logic [RAM_ADDR_BITS-1:0] tag_q, tag_d;
    logic                     inflight_q, inflight_d;
    logic [1:0]               count_q, count_d;
    entry_t                   buf0_q, buf0_d;
    entry_t                   buf1_q, buf1_d;

    logic                     redirect;
    logic                     bypass;
    logic                     pop;
    logic                     push;
    logic                     issue;
    logic [2:0]               occ;
    entry_t                   in_entry;
    entry_t                   head;

    // Stream and buffer. The word arriving from memory is presented directly
    // when the buffer is empty, which is what gives the two-cycle start latency.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        redirect    = redirect_valid && (state_q != S_IDLE);
        in_entry    = '{addr: tag_q, data: mem_out_data};
        bypass      = inflight_q && (count_q == 2'd0);
        head        = bypass ? in_entry : buf0_q;
        instr_valid = inflight_q || (count_q != 2'd0);
        instr_data  = head.data;
        instr_addr  = head.addr;
        pop         = instr_valid && instr_ready;
        occ         = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue       = (state_q == S_FETCH) && !redirect && (occ < 3'd2);
        push        = inflight_q && !redirect && !(pop && bypass);

        mem_enable       = issue;
        mem_address      = issue ? pc_q : '0;
        mem_write_enable = 1'b0;
        mem_in_data      = '0;

        inflight_d = issue;
        tag_d      = issue ? pc_q : tag_q;

        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        count_d = count_q;
        if (redirect) begin
            count_d = 2'd0;
        end else if (pop && !bypass) begin
            buf0_d = buf1_q;
            if (push) begin
                if (count_q == 2'd1) buf0_d = in_entry;
                else                 buf1_d = in_entry;
            end
            count_d = count_q - 2'd1 + {1'b0, push};
        end else if (push) begin
            if (count_q == 2'd0) buf0_d = in_entry;
            else                 buf1_d = in_entry;
            count_d = count_q + 2'd1;
        end
    end

    // Run control; a redirect overrides both issue and completion.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done    = 1'b0;
        busy    = (state_q == S_FETCH) || (state_q == S_DRAIN);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = START_A;
                    state_d = S_FETCH;
                end
            end
            S_FETCH, S_DRAIN: begin
                if (redirect) begin
                    pc_d    = redirect_addr;
                    state_d = (redirect_addr > END_A) ? S_DRAIN : S_FETCH;
                end else if (state_q == S_FETCH) begin
                    if (issue) begin
                        pc_d = pc_q + RAM_ADDR_BITS'(1);
                        if (pc_q == END_A) state_d = S_DRAIN;
                    end
                end else if (!inflight_q && (count_q == 2'd0)) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the two buffer entries are reset too, so instr_data/instr_addr read 0 out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule

// File: tb/tb_prg_fetch.sv
// Scoreboard bench for prg_fetch: expected {addr, word} pairs are queued at start
// and popped on every valid&ready transfer. A second instance covers the top-of-memory run.
module tb_prg_fetch;

    localparam int AW = 9;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic          start_a = 1'b0, start_b = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          instr_ready = 1'b0;
    logic          sel = 1'b0;

    logic          a_mem_en, a_mem_we, a_valid, a_busy, a_done;
    logic [AW-1:0] a_mem_addr, a_addr;
    logic [DW-1:0] a_mem_wdata, a_mem_rdata, a_data;
    logic          b_mem_en, b_mem_we, b_valid, b_busy, b_done;
    logic [AW-1:0] b_mem_addr, b_addr;
    logic [DW-1:0] b_mem_wdata, b_mem_rdata, b_data;

    prg_fetch #(.RAM_WIDTH(DW), .RAM_ADDR_BITS(AW), .START_ADDR(0), .END_ADDR(8)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .mem_enable(a_mem_en), .mem_write_enable(a_mem_we), .mem_address(a_mem_addr),
        .mem_in_data(a_mem_wdata), .mem_out_data(a_mem_rdata),
        .instr_valid(a_valid), .instr_ready(instr_ready), .instr_data(a_data),
        .instr_addr(a_addr), .busy(a_busy), .done(a_done)
    );

    prg_fetch #(.RAM_WIDTH(DW), .RAM_ADDR_BITS(AW), .START_ADDR(510), .END_ADDR(511)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b),
        .redirect_valid(1'b0), .redirect_addr('0),
        .mem_enable(b_mem_en), .mem_write_enable(b_mem_we), .mem_address(b_mem_addr),
        .mem_in_data(b_mem_wdata), .mem_out_data(b_mem_rdata),
        .instr_valid(b_valid), .instr_ready(instr_ready), .instr_data(b_data),
        .instr_addr(b_addr), .busy(b_busy), .done(b_done)
    );

    // Program memories preloaded with word = addr + 0x100, 1-cycle registered read.
    always_ff @(posedge clock) if (a_mem_en) a_mem_rdata <= 32'h100 + 32'(a_mem_addr);
    always_ff @(posedge clock) if (b_mem_en) b_mem_rdata <= 32'h100 + 32'(b_mem_addr);

    logic          m_valid, m_busy, m_done;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    always_comb begin
        m_valid = sel ? b_valid : a_valid;
        m_busy  = sel ? b_busy  : a_busy;
        m_done  = sel ? b_done  : a_done;
        m_addr  = sel ? b_addr  : a_addr;
        m_data  = sel ? b_data  : a_data;
    end

    exp_t          sbq[$];
    int            total = 0, bad = 0;
    int            cyc, done_cnt, xfers, first_x, last_x, done_cyc;
    logic          prev_stall, prev_redir;
    logic [DW-1:0] prev_d;
    logic [AW-1:0] prev_a;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic ready_pat(input int mode, input int i);
        if (mode == 0) return 1'b1;
        return (i % 4 == 0) || (i % 4 == 3);
    endfunction

    task automatic clear_book();
        cyc = 0; done_cnt = 0; xfers = 0; first_x = -1; last_x = -1; done_cyc = -1;
        prev_stall = 1'b0; prev_redir = 1'b0; prev_d = '0; prev_a = '0;
    endtask

    task automatic push_run(input int first, input int last);
        for (int a = first; a <= last; a++)
            sbq.push_back('{addr: AW'(a), data: 32'h100 + 32'(a)});
    endtask

    task automatic monitor();
        exp_t e;
        cyc++;
        if (dut_a.count_q > 2'd2) check("overflow_a", dut_a.count_q, 2);
        if (dut_b.count_q > 2'd2) check("overflow_b", dut_b.count_q, 2);
        if (prev_stall && !prev_redir) begin
            check("hold_data", m_data, prev_d);
            check("hold_addr", m_addr, prev_a);
        end
        if (m_valid && instr_ready) begin
            if (sbq.size() == 0) begin
                check("extra_xfer", m_addr, 64'hFFFF);
            end else begin
                e = sbq.pop_front();
                check("xfer_addr", m_addr, e.addr);
                check("xfer_data", m_data, e.data);
            end
            xfers++;
            last_x = cyc;
            if (first_x < 0) first_x = cyc;
        end
        if (m_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_stall = m_valid && !instr_ready;
        prev_redir = redirect_valid;
        prev_d = m_data;
        prev_a = m_addr;
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic tick(input logic r, input logic st, input logic rv, input logic [AW-1:0] ra);
        @(posedge clock);
        #1;
        instr_ready    = r;
        start_a        = st && !sel;
        start_b        = st && sel;
        redirect_valid = rv;
        redirect_addr  = ra;
        @(negedge clock);
        monitor();
    endtask

    task automatic begin_scn(input logic s);
        reset_n = 1'b0;
        sel = s;
        start_a = 1'b0; start_b = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        sbq.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        clear_book();
    endtask

    task automatic run_to_done(input int mode, input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(ready_pat(mode, i), 1'b0, 1'b0, '0);
            if (m_done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        tick(1'b1, 1'b0, 1'b0, '0);
        check("busy_low", m_busy, 0);
        check("done_once", done_cnt, 1);
        check("sb_empty", sbq.size(), 0);
    endtask

    initial begin
        // Reset values while reset_n is held low.
        repeat (2) @(posedge clock);
        #1;
        check("rst_mem_en", a_mem_en, 0);
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_mem_we", a_mem_we, 0);
        check("rst_mem_wdata", a_mem_wdata, 0);
        check("rst_valid", a_valid, 0);
        check("rst_data", a_data, 0);
        check("rst_addr", a_addr, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);

        // Full run, ready held high.
        begin_scn(1'b0);
        push_run(0, 8);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("idle_busy", a_busy, 0);
        tick(1'b1, 1'b0, 1'b0, '0);
        check("lat_mem_en", a_mem_en, 1);
        check("lat_mem_addr", a_mem_addr, 0);
        check("lat_valid0", a_valid, 0);
        check("lat_busy", a_busy, 1);
        tick(1'b1, 1'b0, 1'b0, '0);
        check("lat_valid1", a_valid, 1);
        run_to_done(0, 40);
        check("xfers_full", xfers, 9);
        check("back_to_back", last_x - first_x, 8);
        check("done_after_last", done_cyc - last_x, 1);

        // Same run under 1,0,0,1 backpressure.
        begin_scn(1'b0);
        push_run(0, 8);
        tick(1'b1, 1'b1, 1'b0, '0);
        run_to_done(1, 200);
        check("xfers_stall", xfers, 9);

        // Redirect to 5 while head is 2 and 3 is in flight.
        begin_scn(1'b0);
        push_run(0, 1);
        push_run(5, 8);
        tick(1'b1, 1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b0, '0);
        check("pre_issue3", a_mem_addr, 3);
        check("pre_head2", a_addr, 2);
        tick(1'b0, 1'b0, 1'b1, AW'(5));
        check("redir_head", a_addr, 2);
        check("redir_no_issue", a_mem_en, 0);
        tick(1'b0, 1'b0, 1'b0, '0);
        check("flushed", a_valid, 0);
        check("redir_busy", a_busy, 1);
        run_to_done(0, 40);
        check("xfers_redir", xfers, 6);

        // Redirect beyond END_ADDR ends the run; the pop in the redirect cycle completes.
        begin_scn(1'b0);
        push_run(0, 1);
        tick(1'b1, 1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b1, AW'(20));
        check("far_no_issue", a_mem_en, 0);
        run_to_done(0, 10);
        check("xfers_far", xfers, 2);

        // Top of memory: exactly 510 and 511, no wrap.
        begin_scn(1'b1);
        push_run(510, 511);
        tick(1'b1, 1'b1, 1'b0, '0);
        run_to_done(0, 20);
        check("xfers_wrap", xfers, 2);

        // Reset mid-run with data waiting, then a clean rerun.
        begin_scn(1'b0);
        tick(1'b0, 1'b1, 1'b0, '0);
        repeat (4) tick(1'b0, 1'b0, 1'b0, '0);
        check("mid_valid", a_valid, 1);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", a_valid, 0);
        check("mid_rst_mem_en", a_mem_en, 0);
        check("mid_rst_mem_addr", a_mem_addr, 0);
        check("mid_rst_data", a_data, 0);
        check("mid_rst_addr", a_addr, 0);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_done", a_done, 0);
        begin_scn(1'b0);
        push_run(0, 8);
        tick(1'b1, 1'b1, 1'b0, '0);
        run_to_done(0, 40);
        check("xfers_rerun", xfers, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prg_fetch.md
Name: prg_fetch

Overview:
- Sequential read-side client of the single-port program memory. The memory has a 1-cycle registered read, updates its output only when enabled, and has no write path used here.
- Walks addresses START_ADDR..END_ADDR, drives the memory port, and presents each word with its address on a valid/ready stream to the core or debug consumer.
- Supports a mid-run redirect (jump) that squashes stale data. Absorbs consumer backpressure with a 2-entry buffer, so a held-high ready yields 1 word per cycle.

Parameters:
- RAM_WIDTH, 32, data word width; matches the memory.
- RAM_ADDR_BITS, 9, address width; matches the memory.
- START_ADDR, 0, first address fetched after start.
- END_ADDR, 8, last address fetched. A run ends after this address is issued. Must satisfy END_ADDR <= 2**RAM_ADDR_BITS-1.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a run from START_ADDR when idle
- redirect_valid  in  1  pulse; jump to redirect_addr during a run
- redirect_addr  in  RAM_ADDR_BITS  jump target
- mem_enable  out  1  drives the memory's ram_enable
- mem_write_enable  out  1  constant 0
- mem_address  out  RAM_ADDR_BITS  read address
- mem_in_data  out  RAM_WIDTH  constant 0
- mem_out_data  in  RAM_WIDTH  registered read data from the memory
- instr_valid  out  1  head buffer entry valid
- instr_ready  in  1  consumer accepts; transfer = valid & ready
- instr_data  out  RAM_WIDTH  word at head
- instr_addr  out  RAM_ADDR_BITS  address of word at head
- busy  out  1  high in FETCH or DRAIN
- done  out  1  single-cycle pulse at end of run

Behaviour:
- Reset (async assert, sync release): state IDLE, pc=0, buffer empty, in-flight flag 0. All outputs 0 (mem_enable, mem_address, instr_valid, instr_data, instr_addr, busy, done).
- States and transitions:
  - IDLE: start=1 -> pc<=START_ADDR, go to FETCH. redirect_valid is ignored.
  - FETCH: issue a read when occupancy + inflight - pop < 2, where pop = instr_valid & instr_ready in the same cycle. Issue means mem_enable=1, mem_address=pc, pc<=pc+1 (mod 2**RAM_ADDR_BITS), inflight<=1 with the issued address tagged. Issuing pc==END_ADDR -> go to DRAIN.
  - DRAIN: no issues; wait for inflight=0 and buffer empty -> done=1 for one cycle, go to IDLE.
- Capture: the cycle after an issue, mem_out_data is pushed with the tagged address unless squashed. mem_enable is 0 whenever no issue occurs; the memory holds its last data, which is never captured twice.
- Buffer: 2-entry FIFO; head drives instr_data/instr_addr. Push and pop in the same cycle are legal at any occupancy.
  - Issue gating guarantees no overflow; an overflow push is a design error and the bench asserts on it.
  - While instr_valid=1 and instr_ready=0, instr_data/instr_addr must hold stable.
- Latency: start at edge N -> first mem_enable in cycle N+1 -> instr_valid in cycle N+2.
- Steady state: instr_ready held high gives 1 word/cycle.
- Redirect (FETCH or DRAIN): flush buffer (instr_valid=0 next cycle), squash any in-flight read, pc<=redirect_addr, state<=FETCH. No issue occurs in the redirect cycle.
  - If redirect_addr > END_ADDR: go straight to DRAIN instead, and done follows once the squashed in-flight read retires.
  - Redirect has priority over issue and pop in the same cycle; a pop in that cycle is still a completed transfer.
- start outside IDLE is ignored.
- Address wrap: pc increments modulo 2**RAM_ADDR_BITS. END_ADDR=2**RAM_ADDR_BITS-1 ends the run without a wrapped fetch.
- Reset mid-run: immediate return to reset values; no done pulse.

Test Plan:
- Memory preloaded with word=addr+0x100; START=0, END=8, start pulse, ready=1 -> 9 transfers, addr 0..8, data 0x100..0x108, consecutive cycles, first instr_valid 2 cycles after start, done one cycle after last transfer.
- Same run with ready toggling 1,0,0,1 repeating -> no loss or duplication, data stable while stalled, buffer never exceeds 2.
- Redirect to 5 while head is addr 2 and addr 3 in flight -> stale words 2,3 never appear; next transfer is addr 5, then 6,7,8, done.
- Redirect to 20 with END=8 -> no further transfers, done pulses, busy falls.
- START=510, END=511, RAM_ADDR_BITS=9 -> exactly 2 words (510, 511), no wrap to 0.
- reset_n low mid-run while instr_valid=1 -> all outputs 0 immediately; new start re-fetches from START_ADDR correctly.
